alu_result_fifo: RTL and testbench



---
 rtl/alu_result_fifo.sv | 88 ++++++++
 tb/tb_alu_result_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO that buffers ALU results with their code and zero/arith flags.
// Latency: an entry written at an edge appears at the head the next cycle. Backpressure: in_ready depends only on count and drops when full.
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_code,
  input  logic [7:0]                 in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_code,
  output logic [7:0]                 out_result,
  output logic                       out_zero,
  output logic                       out_flag,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0] code;
    logic [7:0] result;
    logic       zero;
    logic       flag;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          arith_flag;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flag meaning depends on the operation: carry for add, borrow for sub, overflow for mul.
  always_comb begin
    arith_flag = 1'b0;
    case (in_code)
      3'd0:    arith_flag = in_result[4];
      3'd1:    arith_flag = in_result[7];
      3'd3:    arith_flag = |in_result[7:4];
      default: arith_flag = 1'b0;
    endcase
  end

  always_comb begin
    wr_entry.code   = in_code;
    wr_entry.result = in_result;
    wr_entry.zero   = (in_result == 8'h00);
    wr_entry.flag   = arith_flag;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign out_code   = head.code;
  assign out_result = head.result;
  assign out_zero   = head.zero;
  assign out_flag   = head.flag;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo with hand-computed expectations.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic [7:0] in_result;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic [7:0] out_result;
  logic       out_zero;
  logic       out_flag;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;

  alu_result_fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_result(out_result), .out_zero(out_zero), .out_flag(out_flag),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [2:0] c, input logic [7:0] r);
    in_valid  = 1'b1;
    in_code   = c;
    in_result = r;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic flag_case(input logic [2:0] c, input logic [7:0] r,
                           input logic z, input logic f);
    push_one(c, r);
    chk("flag_valid", 32'(out_valid), 32'd1);
    chk("flag_result", 32'(out_result), 32'(r));
    chk("flag_zero", 32'(out_zero), 32'(z));
    chk("flag_flag", 32'(out_flag), 32'(f));
    pop_one();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_result = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // First push: 4+5
    push_one(3'd0, 8'h09);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_result", 32'(out_result), 32'h09);
    chk("t1_zero", 32'(out_zero), 32'd0);
    chk("t1_flag", 32'(out_flag), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    pop_one();
    chk("t1_count_after_pop", 32'(count), 32'd0);

    // Flag table
    flag_case(3'd1, 8'hFF, 1'b0, 1'b1);
    flag_case(3'd3, 8'h14, 1'b0, 1'b1);
    flag_case(3'd0, 8'h1E, 1'b0, 1'b1);
    flag_case(3'd4, 8'h00, 1'b1, 1'b0);
    flag_case(3'd2, 8'hF0, 1'b0, 1'b0);
    flag_case(3'd0, 8'h0F, 1'b0, 1'b0);
    flag_case(3'd1, 8'h01, 1'b0, 1'b0);
    flag_case(3'd3, 8'h0C, 1'b0, 1'b0);

    // Fill with consumer stalled
    for (int i = 0; i < 4; i++) push_one(3'(i), 8'h10 + 8'(i));
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    push_one(3'd7, 8'hAA);
    chk("fill_drop_count", 32'(count), 32'd4);
    chk("fill_head_code", 32'(out_code), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_code", 32'(out_code), 32'(i));
      chk("drain_result", 32'(out_result), 32'h10 + 32'(i));
      // add: bit4 set; sub: bit7 clear; code2: 0; mul 0x13: upper nibble nonzero
      chk("drain_flag", 32'(out_flag), (i == 0 || i == 3) ? 32'd1 : 32'd0);
      pop_one();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Sustained push+pop across pointer wrap
    push_one(3'd2, 8'h20);
    push_one(3'd2, 8'h21);
    chk("stream_start_count", 32'(count), 32'd2);
    in_valid = 1'b1; out_ready = 1'b1; in_code = 3'd2;
    for (int k = 0; k < 6; k++) begin
      in_result = 8'h22 + 8'(k);
      chk("stream_head", 32'(out_result), 32'h20 + 32'(k));
      tick();
      chk("stream_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    chk("stream_tail0", 32'(out_result), 32'h26);
    tick();
    chk("stream_tail1", 32'(out_result), 32'h27);
    tick();
    out_ready = 1'b0;
    chk("stream_empty", 32'(count), 32'd0);

    // Full with simultaneous in_valid and out_ready
    for (int i = 0; i < 4; i++) push_one(3'd5, 8'h30 + 8'(i));
    chk("full_count", 32'(count), 32'd4);
    in_valid = 1'b1; in_code = 3'd6; in_result = 8'h99; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_in_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("full_drain", 32'(out_result), 32'h30 + 32'(i));
      pop_one();
    end
    chk("full_drain_count", 32'(count), 32'd0);

    // Reset mid-operation overrides a concurrent push and pop
    for (int i = 0; i < 3; i++) push_one(3'd1, 8'h40 + 8'(i));
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1; in_valid = 1'b1; in_code = 3'd0; in_result = 8'h55; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    push_one(3'd2, 8'h0C);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_result", 32'(out_result), 32'h0C);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
